// File: rtl/mem_arb_pkg.sv
// Shared definitions for the single-port memory arbiter: FSM states, owner
// encoding and the legal parameter ranges.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int MEM_LAT_MIN    = 1;
    localparam int MEM_LAT_MAX    = 7;
    localparam int STARVE_MAX_MIN = 1;
    localparam int STARVE_MAX_MAX = 15;

    localparam int LAT_CNT_W    = 3;
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_fairness.sv
// Winner select between fetch and data requests, with a starvation counter
// that forces an IF grant after STARVE_MAX back-to-back D wins.
module mem_arb_fairness
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic sample,
    output logic grant_if,
    output logic grant_d
);

    localparam int SMAX = (STARVE_MAX < STARVE_MAX_MIN) ? STARVE_MAX_MIN :
                          (STARVE_MAX > STARVE_MAX_MAX) ? STARVE_MAX_MAX : STARVE_MAX;
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(SMAX);

    logic [STARVE_CNT_W-1:0] starve_cnt;

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (sample) begin
            if (if_req && d_req) begin
                if (starve_cnt < STARVE_LIM) begin
                    grant_d = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Only D wins taken while IF is waiting count toward starvation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt < STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter16.sv
// Shares one 16-bit memory port between instruction fetch and load/store,
// one access in flight at a time, with fully registered outputs.
module mem_port_arbiter16
    import mem_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [LAT_CNT_W-1:0] LAT_RELOAD = LAT_CNT_W'(LAT - 1);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST   = LAT_CNT_W'(1);

    arb_state_t           state;
    arb_state_t           next_state;
    owner_t               owner;
    logic                 acc_we;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic [LAT_CNT_W-1:0] next_lat_cnt;

    logic sample;
    logic grant_if;
    logic grant_d;

    logic next_if_gnt;
    logic next_d_gnt;
    logic next_mem_re;
    logic next_mem_we;
    logic next_if_rvalid;
    logic next_d_done;
    logic next_busy;

    assign sample = (state == IDLE);

    mem_arb_fairness #(
        .STARVE_MAX (STARVE_MAX)
    ) u_fairness (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .d_req    (d_req),
        .sample   (sample),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    always_comb begin
        next_state     = state;
        next_lat_cnt   = lat_cnt;
        next_if_gnt    = 1'b0;
        next_d_gnt     = 1'b0;
        next_mem_re    = 1'b0;
        next_mem_we    = 1'b0;
        next_if_rvalid = 1'b0;
        next_d_done    = 1'b0;

        case (state)
            IDLE: begin
                if (grant_if) begin
                    next_state  = ISSUE;
                    next_if_gnt = 1'b1;
                    next_mem_re = 1'b1;
                end else if (grant_d) begin
                    next_state  = ISSUE;
                    next_d_gnt  = 1'b1;
                    next_mem_re = !d_we;
                    next_mem_we = d_we;
                end
            end
            ISSUE: begin
                if (acc_we || (LAT == 1)) begin
                    next_state = RESP;
                end else begin
                    next_state   = WAIT;
                    next_lat_cnt = LAT_RELOAD;
                end
            end
            WAIT: begin
                next_lat_cnt = lat_cnt - 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // The response pulse is registered on the same edge that captures mem_rdata.
        if (next_state == RESP) begin
            next_if_rvalid = (owner == OWN_IF);
            next_d_done    = (owner == OWN_D);
        end
    end

    assign next_busy = (next_state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            if_rvalid <= 1'b0;
            d_done    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            lat_cnt   <= next_lat_cnt;
            if_gnt    <= next_if_gnt;
            d_gnt     <= next_d_gnt;
            mem_re    <= next_mem_re;
            mem_we    <= next_mem_we;
            if_rvalid <= next_if_rvalid;
            d_done    <= next_d_done;
            busy      <= next_busy;
        end
    end

    // mem_addr/mem_wdata double as the latched access; they hold after ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= OWN_IF;
            acc_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_if) begin
                owner    <= OWN_IF;
                acc_we   <= 1'b0;
                mem_addr <= if_addr;
            end else if (grant_d) begin
                owner     <= OWN_D;
                acc_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end
            if (next_if_rvalid) begin
                if_rdata <= mem_rdata;
            end
            if (next_d_done && !acc_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter16.sv
// Bench for mem_port_arbiter16: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// each with a behavioural memory, response scoreboards and cycle checks.
module tb_mem_port_arbiter16;

    typedef struct {
        bit          port_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_a, rst_b;
    logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_done;
    logic        a_mem_re, a_mem_we, a_busy;
    logic [15:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_done;
    logic        b_mem_re, b_mem_we, b_busy;
    logic [15:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter16 #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_done(a_d_done), .d_rdata(a_d_rdata),
        .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter16 #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models: read data is only valid in the cycle it must be sampled.
    logic [15:0] mem_a [0:1023];
    logic [15:0] mem_b [0:1023];
    logic [1:0]  b_pv = 2'b00;
    logic [15:0] b_pd0, b_pd1;

    assign a_mem_rdata = a_mem_re ? mem_a[a_mem_addr[9:0]] : 16'h0BAD;
    assign b_mem_rdata = b_pv[1] ? b_pd1 : 16'h0BAD;

    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr[9:0]] <= a_mem_wdata;
        if (b_mem_we) mem_b[b_mem_addr[9:0]] <= b_mem_wdata;
        b_pv  <= {b_pv[0], b_mem_re};
        b_pd0 <= mem_b[b_mem_addr[9:0]];
        b_pd1 <= b_pd0;
    end

    logic [15:0] exp_a_if[$];
    logic [15:0] exp_a_d[$];
    logic [15:0] exp_b_if[$];
    logic [15:0] exp_b_d[$];
    logic [15:0] mdl_a_d_rdata = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: response with no outstanding request", name);
    endtask

    always @(negedge clk) begin
        check("a_strobe_excl", 32'(a_mem_re & a_mem_we), 32'd0);
        check("b_strobe_excl", 32'(b_mem_re & b_mem_we), 32'd0);
        if (a_if_rvalid) begin
            if (exp_a_if.size() == 0) unexpected("a_if_rvalid");
            else check("a_if_rdata", 32'(a_if_rdata), 32'(exp_a_if.pop_front()));
        end
        if (a_d_done) begin
            if (exp_a_d.size() == 0) unexpected("a_d_done");
            else check("a_d_rdata", 32'(a_d_rdata), 32'(exp_a_d.pop_front()));
        end
        if (b_if_rvalid) begin
            if (exp_b_if.size() == 0) unexpected("b_if_rvalid");
            else check("b_if_rdata", 32'(b_if_rdata), 32'(exp_b_if.pop_front()));
        end
        if (b_d_done) begin
            if (exp_b_d.size() == 0) unexpected("b_d_done");
            else check("b_d_rdata", 32'(b_d_rdata), 32'(exp_b_d.pop_front()));
        end
    end

    // Called #1 after the edge that starts cycle 0 of a transaction on DUT a.
    task automatic a_run(input vec_t v);
        int n;
        bit seen;
        if (v.port_d) begin
            a_d_req = 1'b1; a_d_we = v.we; a_d_addr = v.addr; a_d_wdata = v.wdata;
            if (v.we) begin
                exp_a_d.push_back(mdl_a_d_rdata);
            end else begin
                exp_a_d.push_back(v.exp);
                mdl_a_d_rdata = v.exp;
            end
        end else begin
            a_if_req = 1'b1; a_if_addr = v.addr;
            exp_a_if.push_back(v.exp);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = v.port_d ? a_d_gnt : a_if_gnt;
        end
        check("gnt_cycle", 32'(n), 32'd1);
        if (seen) begin
            check("gnt_pair", 32'({a_if_gnt, a_d_gnt}), v.port_d ? 32'd1 : 32'd2);
            check("issue_re", 32'(a_mem_re), 32'(!(v.port_d && v.we)));
            check("issue_we", 32'(a_mem_we), 32'(v.port_d && v.we));
            check("issue_addr", 32'(a_mem_addr), 32'(v.addr));
            check("issue_busy", 32'(a_busy), 32'd1);
            if (v.port_d && v.we) check("issue_wdata", 32'(a_mem_wdata), 32'(v.wdata));
        end
        a_if_req = 1'b0;
        a_d_req  = 1'b0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = v.port_d ? a_d_done : a_if_rvalid;
        end
        check("resp_cycle", 32'(n), 32'd2);
    endtask

    vec_t tbl[10];
    bit   ord_exp[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit   ord_got[10];
    bit   b_busy_exp[6]   = '{1, 1, 1, 1, 0, 1};
    bit   b_dgnt_exp[6]   = '{1, 0, 0, 0, 0, 0};
    bit   b_ifgnt_exp[6]  = '{0, 0, 0, 0, 0, 1};
    bit   b_ddone_exp[6]  = '{0, 0, 0, 1, 0, 0};
    bit   b_re_exp[6]     = '{1, 0, 0, 0, 0, 1};

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int ng;
        int cyc;
        bit seen;

        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3};
        tbl[1] = '{1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF};
        tbl[3] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF};
        tbl[4] = '{1'b1, 1'b1, 16'h0011, 16'h5A5A, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hA5C3};
        tbl[6] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h5A5A};
        tbl[7] = '{1'b1, 1'b1, 16'h03FF, 16'hFFFF, 16'h0000};
        tbl[8] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'hFFFF};
        tbl[9] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h5A5A};

        mem_a[10'h010] = 16'hA5C3;
        mem_a[10'h040] = 16'h1234;
        mem_b[10'h010] = 16'h1111;
        mem_b[10'h040] = 16'h7E57;

        rst_a = 1'b1; rst_b = 1'b1;
        a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        a_if_req = 1'b1; a_if_addr = 16'h0010;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ctl", 32'({a_if_gnt, a_if_rvalid, a_d_gnt, a_d_done, a_mem_re, a_mem_we, a_busy}), 32'd0);
        check("rst_a_rdata", 32'({a_if_rdata, a_d_rdata}), 32'd0);
        check("rst_a_mem", 32'({a_mem_addr, a_mem_wdata}), 32'd0);
        check("rst_b_ctl", 32'({b_if_gnt, b_if_rvalid, b_d_gnt, b_d_done, b_mem_re, b_mem_we, b_busy}), 32'd0);

        rst_a = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            a_run(tbl[i]);
        end

        // A request withdrawn before IDLE samples it must be ignored.
        @(posedge clk); #1;
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 16'h0040; a_d_wdata = 16'hDEAD;
        @(negedge clk);
        a_d_req = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("dropped_req", 32'({a_if_gnt, a_d_gnt, a_busy, a_mem_we}), 32'd0);
        end

        // Both requesters held high: D wins four times, then IF is forced.
        a_if_req = 1'b1; a_if_addr = 16'h0010;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h0040;
        ng = 0;
        cyc = 0;
        while (ng < 10 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (a_if_gnt) begin
                ord_got[ng] = 1'b0; ng++;
                exp_a_if.push_back(16'hA5C3);
            end else if (a_d_gnt) begin
                ord_got[ng] = 1'b1; ng++;
                exp_a_d.push_back(16'h1234);
                mdl_a_d_rdata = 16'h1234;
            end
        end
        a_if_req = 1'b0;
        a_d_req  = 1'b0;
        check("contention_grants", 32'(ng), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < ng) check($sformatf("grant_order_%0d", i), 32'(ord_got[i]), 32'(ord_exp[i]));
        end
        repeat (4) @(posedge clk);

        // MEM_LAT=3 load; IF presents a request right after the D grant.
        @(posedge clk); #1;
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 16'h0040;
        exp_b_d.push_back(16'h7E57);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("lat3_busy_c%0d", c + 1), 32'(b_busy), 32'(b_busy_exp[c]));
            check($sformatf("lat3_dgnt_c%0d", c + 1), 32'(b_d_gnt), 32'(b_dgnt_exp[c]));
            check($sformatf("lat3_ifgnt_c%0d", c + 1), 32'(b_if_gnt), 32'(b_ifgnt_exp[c]));
            check($sformatf("lat3_ddone_c%0d", c + 1), 32'(b_d_done), 32'(b_ddone_exp[c]));
            check($sformatf("lat3_re_c%0d", c + 1), 32'(b_mem_re), 32'(b_re_exp[c]));
            if (c == 0) begin
                check("lat3_addr", 32'(b_mem_addr), 32'h0040);
                b_d_req = 1'b0;
                b_if_req = 1'b1; b_if_addr = 16'h0010;
                exp_b_if.push_back(16'h1111);
            end
            if (c == 5) b_if_req = 1'b0;
        end
        seen = 1'b0;
        cyc = 1;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            seen = b_if_rvalid;
        end
        check("lat3_if_resp_cycle", 32'(cyc), 32'd4);

        // Reset during WAIT abandons the load.
        @(posedge clk); #1;
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 16'h0040;
        @(posedge clk); #1;
        check("rstwait_gnt", 32'(b_d_gnt), 32'd1);
        b_d_req = 1'b0;
        @(posedge clk); #1;
        check("rstwait_busy_before", 32'(b_busy), 32'd1);
        rst_b = 1'b0;
        #1;
        check("rstwait_async_ctl", 32'({b_busy, b_d_done, b_mem_re}), 32'd0);
        check("rstwait_async_data", 32'({b_d_rdata, b_mem_addr}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            check("rstwait_after", 32'({b_d_done, b_busy, b_d_gnt}), 32'd0);
        end

        check("a_if_drained", 32'(exp_a_if.size()), 32'd0);
        check("a_d_drained", 32'(exp_a_d.size()), 32'd0);
        check("b_if_drained", 32'(exp_b_if.size()), 32'd0);
        check("b_d_drained", 32'(exp_b_d.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
